mshr_entry_alloc: RTL and testbench
===================================

// Module: mshr_entry_alloc
// PURPOSE
//  Tracks occupancy of ENTRY_NUM MSHR entries. Grants one free entry per cycle over a valid/ready handshake.
//  Reports the granted entry as a binary ID with a "none free" sentinel MSB, and accepts one release per cycle.
//  Sits between the miss-request front end and the MSHR entry array; replaces ad-hoc onehot-to-binary encoders with stateful allocation.
// PARAMETERS
//  ENTRY_NUM     16  number of MSHR entries (>=2)
//  ALLOC_POLICY  0   0 = lowest free index first; 1 = round-robin search starting at rr_ptr
//  ID_WIDTH      $clog2(ENTRY_NUM) (localparam) binary entry index width
//  CNT_WIDTH     $clog2(ENTRY_NUM+1) (localparam) occupancy counter width
// PORTS
//  clk            in   1             clock
//  rst            in   1             synchronous, active-high reset
//  alloc_vld      in   1             requester wants an entry
//  alloc_rdy      out  1             a free entry exists (= ~full)
//  alloc_id       out  ID_WIDTH+1    chosen entry; MSB=1 => none free (all ones)
//  rel_vld        in   1             release strobe
//  rel_id         in   ID_WIDTH      entry being released
//  entry_vld_vec  out  ENTRY_NUM     registered occupancy bitmap
//  used_cnt       out  CNT_WIDTH     registered number of occupied entries
//  full           out  1             used_cnt == ENTRY_NUM
//  empty          out  1             used_cnt == 0
//  err_rel_free   out  1             sticky: release of an unoccupied entry or out-of-range rel_id
// BEHAVIOUR
//  - Reset: entry_vld_vec=0, used_cnt=0, rr_ptr=0, err_rel_free=0.
//    Outputs follow: empty=1, full=0, alloc_rdy=1, alloc_id=0.
//  - alloc_id and alloc_rdy are combinational from registered state only; no dependence on alloc_vld or rel_vld.
//  - Selection:
//    - Policy 0: lowest index i with entry_vld_vec[i]==0.
//    - Policy 1: first free index scanning rr_ptr, rr_ptr+1, ... mod ENTRY_NUM.
//    - No free entry: alloc_id = {(ID_WIDTH+1){1'b1}}, alloc_rdy=0.
//  - Handshake: grant occurs when alloc_vld & alloc_rdy in a cycle.
//    - Next cycle: entry_vld_vec[alloc_id]=1.
//    - Policy 1: rr_ptr <= (alloc_id+1) mod ENTRY_NUM. rr_ptr changes only on grant.
//  - Release: rel_vld with entry_vld_vec[rel_id]==1 clears that bit next cycle.
//    - rel_vld with the bit already 0, or rel_id >= ENTRY_NUM: no state change, err_rel_free <= 1.
//    - err_rel_free holds until reset.
//  - Same-cycle grant and release:
//    - Both take effect; used_cnt unchanged.
//    - The released entry is not eligible for that cycle's grant; it becomes selectable the following cycle.
//    - No bypass when full: alloc_rdy stays 0 in a cycle with rel_vld while full.
//  - Counter: used_cnt += grant - valid_release; never wraps (bounded by the rules above).
//  - Reset mid-operation: all entries return to free in one cycle. Any handshake in the reset cycle is ignored.
//  - Assertions (sim only):
//    - popcount(entry_vld_vec)==used_cnt.
//    - alloc_id MSB==~alloc_rdy.
//    - alloc_vld held high while alloc_rdy=0 is legal.
// TESTING
//  1 Reset, policy 0, ENTRY_NUM=4, alloc_vld=1 for 4 cycles
//      -> alloc_id 0,1,2,3.
//      -> full=1, alloc_id=3'b111, alloc_rdy=0, used_cnt=4.
//  2 From full, rel_vld rel_id=2 -> next cycle alloc_id=2, alloc_rdy=1, used_cnt=3.
//  3 Policy 1: grant 0,1; release 0; alloc again
//      -> alloc_id=2 (rr_ptr=2), not 0.
//      -> After 2,3 granted, next grant wraps to 0.
//  4 Same cycle: grant and release id=1, with entries 0,1 held
//      -> grant picks 2, entry 1 free next cycle, used_cnt stays 2.
//  5 Release id=3 while entry 3 free
//      -> err_rel_free=1 next cycle and stays 1.
//      -> entry_vld_vec and used_cnt unchanged.
//  6 Assert rst with 3 entries held and alloc_vld=1
//      -> next cycle entry_vld_vec=0, used_cnt=0, empty=1, alloc_id=0.

Source files
------------

// File: rtl/mshr_entry_alloc.sv
// MSHR entry allocator: tracks occupancy of ENTRY_NUM entries, grants one
// free entry per cycle over valid/ready and accepts one release per cycle.
module mshr_entry_alloc #(
  parameter int unsigned ENTRY_NUM    = 16,
  parameter int unsigned ALLOC_POLICY = 0,
  localparam int unsigned ID_WIDTH    = $clog2(ENTRY_NUM),
  localparam int unsigned CNT_WIDTH   = $clog2(ENTRY_NUM + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_vld_i,
  output logic                 alloc_rdy_o,
  output logic [ID_WIDTH:0]    alloc_id_o,
  input  logic                 rel_vld_i,
  input  logic [ID_WIDTH-1:0]  rel_id_i,
  output logic [ENTRY_NUM-1:0] entry_vld_vec_o,
  output logic [CNT_WIDTH-1:0] used_cnt_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 err_rel_free_o
);

  logic [ENTRY_NUM-1:0] vld_q, vld_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                 err_q, err_d;

  logic                 sel_found;
  logic [ID_WIDTH-1:0]  sel_idx;
  logic                 grant;
  logic                 rel_in_range;
  logic                 rel_ok;

  // Free-entry search from registered state only; the start point is 0 for
  // lowest-first or rr_ptr for round-robin. A same-cycle release is still
  // marked busy here, so it cannot be re-granted in the cycle it is freed.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < int'(ENTRY_NUM); k++) begin
      int idx;
      idx = ((ALLOC_POLICY == 1 ? int'(rr_ptr_q) : 0) + k) % int'(ENTRY_NUM);
      if (!sel_found && !vld_q[idx]) begin
        sel_found = 1'b1;
        sel_idx   = ID_WIDTH'(idx);
      end
    end
  end

  // Status outputs and handshake qualification.
  always_comb begin
    full_o          = (cnt_q == CNT_WIDTH'(ENTRY_NUM));
    empty_o         = (cnt_q == '0);
    alloc_rdy_o     = ~full_o;
    alloc_id_o      = full_o ? {(ID_WIDTH + 1){1'b1}} : {1'b0, sel_idx};
    entry_vld_vec_o = vld_q;
    used_cnt_o      = cnt_q;
    err_rel_free_o  = err_q;
    grant           = alloc_vld_i & alloc_rdy_o;
    rel_in_range    = ({1'b0, rel_id_i} < (ID_WIDTH + 1)'(ENTRY_NUM));
    rel_ok          = rel_vld_i & rel_in_range & vld_q[rel_id_i];
  end

  // Next-state: set the granted bit, clear a valid release, track count,
  // advance rr_ptr only on grant, latch bad releases.
  always_comb begin
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q | (rel_vld_i & ~rel_ok);
    if (grant) begin
      vld_d[sel_idx] = 1'b1;
      if (ALLOC_POLICY == 1) begin
        rr_ptr_d = (sel_idx == ID_WIDTH'(ENTRY_NUM - 1)) ? '0 : sel_idx + 1'b1;
      end
    end
    if (rel_ok) begin
      vld_d[rel_id_i] = 1'b0;
    end
    unique case ({grant, rel_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset; reset overrides any handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

`ifndef SYNTHESIS
  // Occupancy bitmap and counter must agree; sentinel MSB mirrors ~ready.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($countones(vld_q) == int'(cnt_q))
        else $error("occupancy count disagrees with bitmap");
      assert (alloc_id_o[ID_WIDTH] == ~alloc_rdy_o)
        else $error("alloc_id sentinel disagrees with alloc_rdy");
    end
  end
`endif

endmodule

// File: tb/tb_mshr_entry_alloc.sv
// Directed bench: a lowest-first and a round-robin instance (4 entries)
// share stimulus; each check targets the instance the scenario is about.
module tb_mshr_entry_alloc;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_vld;
  logic       rel_vld;
  logic [1:0] rel_id;

  logic       rdy0, full0, empty0, err0;
  logic [2:0] id0, cnt0;
  logic [3:0] vec0;
  logic       rdy1, full1, empty1, err1;
  logic [2:0] id1, cnt1;
  logic [3:0] vec1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mshr_entry_alloc #(.ENTRY_NUM(N), .ALLOC_POLICY(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .alloc_vld_i(alloc_vld), .alloc_rdy_o(rdy0),
    .alloc_id_o(id0), .rel_vld_i(rel_vld), .rel_id_i(rel_id),
    .entry_vld_vec_o(vec0), .used_cnt_o(cnt0), .full_o(full0),
    .empty_o(empty0), .err_rel_free_o(err0)
  );

  mshr_entry_alloc #(.ENTRY_NUM(N), .ALLOC_POLICY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .alloc_vld_i(alloc_vld), .alloc_rdy_o(rdy1),
    .alloc_id_o(id1), .rel_vld_i(rel_vld), .rel_id_i(rel_id),
    .entry_vld_vec_o(vec1), .used_cnt_o(cnt1), .full_o(full1),
    .empty_o(empty1), .err_rel_free_o(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alloc_vld = 1'b0; rel_vld = 1'b0; rel_id = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check_eq("rst_id",    id0,    0);
    check_eq("rst_rdy",   rdy0,   1);
    check_eq("rst_empty", empty0, 1);
    check_eq("rst_full",  full0,  0);
    check_eq("rst_cnt",   cnt0,   0);
    check_eq("rst_vec",   vec0,   0);
    check_eq("rst_err",   err0,   0);

    // 1: fill lowest-first, ids 0..3, then full
    alloc_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("fill_id%0d", i), id0, i);
      step();
    end
    alloc_vld = 1'b0;
    check_eq("full_full", full0, 1);
    check_eq("full_id",   id0,   3'b111);
    check_eq("full_rdy",  rdy0,  0);
    check_eq("full_cnt",  cnt0,  4);
    check_eq("full_vec",  vec0,  4'hF);

    // 2: release 2 from full; no bypass while full in the release cycle
    rel_vld = 1'b1; rel_id = 2'd2;
    check_eq("nobypass_rdy", rdy0, 0);
    step();
    rel_vld = 1'b0;
    check_eq("rel2_id",  id0,  2);
    check_eq("rel2_rdy", rdy0, 1);
    check_eq("rel2_cnt", cnt0, 3);

    // 4: hold 0,1 then grant and release id 1 in the same cycle
    rst = 1'b1; step(); rst = 1'b0;
    alloc_vld = 1'b1; step(); step();
    rel_vld = 1'b1; rel_id = 2'd1;
    check_eq("same_id", id0, 2);
    step();
    alloc_vld = 1'b0; rel_vld = 1'b0;
    check_eq("same_vec",  vec0, 4'b0101);
    check_eq("same_cnt",  cnt0, 2);
    check_eq("same_next", id0,  1);

    // 5: release of a free entry is flagged and sticky, no state change
    rel_vld = 1'b1; rel_id = 2'd3;
    step();
    rel_vld = 1'b0;
    check_eq("bad_err", err0, 1);
    check_eq("bad_vec", vec0, 4'b0101);
    check_eq("bad_cnt", cnt0, 2);
    step();
    check_eq("bad_sticky", err0, 1);

    // 6: reset with 3 held and alloc_vld high
    alloc_vld = 1'b1; step();
    check_eq("pre_rst_cnt", cnt0, 3);
    rst = 1'b1; step();
    rst = 1'b0; alloc_vld = 1'b0;
    check_eq("mid_rst_vec",   vec0,   0);
    check_eq("mid_rst_cnt",   cnt0,   0);
    check_eq("mid_rst_empty", empty0, 1);
    check_eq("mid_rst_id",    id0,    0);
    check_eq("mid_rst_err",   err0,   0);

    // 3: round-robin: grant 0,1; release 0; next grant is 2, then 3, then wraps to 0
    alloc_vld = 1'b1;
    check_eq("rr_id0", id1, 0); step();
    check_eq("rr_id1", id1, 1); step();
    alloc_vld = 1'b0; rel_vld = 1'b1; rel_id = 2'd0; step();
    rel_vld = 1'b0;
    check_eq("rr_after_rel", id1, 2);
    check_eq("lo_after_rel", id0, 0);
    alloc_vld = 1'b1; step();
    check_eq("rr_id3", id1, 3); step();
    check_eq("rr_wrap", id1, 0); step();
    alloc_vld = 1'b0;
    check_eq("rr_full", full1, 1);
    check_eq("rr_cnt",  cnt1,  4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
